// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment bus receiver: filters each digit's glyph for stability, decodes it to BCD and
// publishes NDIG-digit frames. Define SEG_INPUT_SYNC_EN to add a 2-flop synchronizer for asynchronous sources.
module seg7_scan_decoder #(
   parameter int NDIG       = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [6:0]        seg_in,
   input  logic [NDIG-1:0]   dig_sel,
   output logic [4*NDIG-1:0] bcd_out,
   output logic              frame_valid,
   output logic [NDIG-1:0]   digit_err
);

   localparam int SW = NDIG + 7;
   localparam int CW = $clog2(STABLE_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYC);
   localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYC - 2);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] PUBLISH = 2'd2;

   logic [SW-1:0]     s_in;
   logic [SW-1:0]     s_q;
   logic [CW-1:0]     cnt;
   logic              same;
   logic [NDIG-1:0]   q_sel;
   logic [6:0]        q_seg;
   logic              sel_onehot;
   logic              capture;
   logic [4:0]        dec;
   logic [4*NDIG-1:0] shadow_nib;
   logic [NDIG-1:0]   shadow_err;
   logic [NDIG-1:0]   mask;
   logic [1:0]        state;

`ifdef SEG_INPUT_SYNC_EN
   logic [SW-1:0] sync1;
   logic [SW-1:0] sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {dig_sel, seg_in};
         sync2 <= sync1;
      end
   end

   assign s_in = sync2;
`else
   assign s_in = {dig_sel, seg_in};
`endif

   // Returns {err, nibble}; unrecognised glyphs decode to F with err set.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'h7E:   r = 5'h00;
         7'h30:   r = 5'h01;
         7'h6D:   r = 5'h02;
         7'h79:   r = 5'h03;
         7'h33:   r = 5'h04;
         7'h5B:   r = 5'h05;
         7'h5F:   r = 5'h06;
         7'h1F:   r = 5'h06;
         7'h70:   r = 5'h07;
         7'h7F:   r = 5'h08;
         7'h7B:   r = 5'h09;
         7'h73:   r = 5'h09;
         default: r = 5'h1F;
      endcase
      return r;
   endfunction

   assign same       = (s_in == s_q);
   assign q_sel      = s_q[SW-1:7];
   assign q_seg      = s_q[6:0];
   assign sel_onehot = (q_sel != '0) && ((q_sel & (q_sel - NDIG'(1))) == '0);
   // Fires once per stable window: the cycle the counter steps onto STABLE_CYC-1.
   assign capture    = same && (cnt == CNT_FIRE) && sel_onehot;
   assign dec        = decode(q_seg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q <= '0;
         cnt <= '0;
      end else begin
         s_q <= s_in;
         if (same) begin
            if (cnt != CNT_MAX)
               cnt <= cnt + CW'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_nib <= '0;
         shadow_err <= '0;
      end else begin
         for (int unsigned i = 0; i < NDIG; i++) begin
            if (capture && q_sel[i]) begin
               shadow_nib[4*i +: 4] <= dec[3:0];
               shadow_err[i]        <= dec[4];
            end
         end
      end
   end

   // Outputs load on entry to PUBLISH so data is already valid while frame_valid is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mask      <= '0;
         bcd_out   <= '0;
         digit_err <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (capture) begin
                  mask  <= mask | q_sel;
                  state <= COLLECT;
               end
            end
            COLLECT: begin
               if (capture)
                  mask <= mask | q_sel;
               if (mask == '1) begin
                  state     <= PUBLISH;
                  bcd_out   <= shadow_nib;
                  digit_err <= shadow_err;
               end
            end
            PUBLISH: begin
               // A capture here seeds the next frame after the clear.
               mask  <= capture ? q_sel : '0;
               state <= capture ? COLLECT : IDLE;
            end
            default: begin
               mask  <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign frame_valid = (state == PUBLISH);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: table-driven frames, hand-written corner sequences and random scans
// checked every cycle against a run-length/frame reference model.
module tb_seg7_scan_decoder;

   localparam int NDIG = 4;
   localparam int SC   = 4;
`ifdef SEG_INPUT_SYNC_EN
   localparam int SYNC_DLY = 2;
`else
   localparam int SYNC_DLY = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg_in;
   logic [3:0]  dig_sel;
   logic [15:0] bcd_out;
   logic        frame_valid;
   logic [3:0]  digit_err;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .dig_sel     (dig_sel),
      .bcd_out     (bcd_out),
      .frame_valid (frame_valid),
      .digit_err   (digit_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Glyphs 0..9 followed by the alternate 6 and 9.
   logic [6:0] legal [12] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                              7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h1F, 7'h73};

   function automatic logic [4:0] ref_decode(input logic [6:0] p);
      for (int d = 0; d < 12; d++) begin
         if (legal[d] == p)
            return (d == 10) ? 5'h06 : (d == 11) ? 5'h09 : {1'b0, 4'(d)};
      end
      return 5'h1F;
   endfunction

   // Reference model: a digit is taken when its {sel,seg} word has been seen for exactly SC
   // consecutive cycles; a full set of digits publishes one cycle later and clears one cycle after that.
   logic [10:0] m_dly1 = '0, m_dly2 = '0, m_prev = '0, m_s;
   int          m_run = 1;
   logic [3:0]  m_mask = '0, m_sherr = '0, m_err = '0;
   logic [15:0] m_shadow = '0, m_bcd = '0;
   logic [4:0]  m_dec;
   bit          m_pend = 0, m_pub = 0, m_old_pend, m_old_pub, m_cap;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_dly1 = '0; m_dly2 = '0; m_prev = '0; m_run = 1;
         m_mask = '0; m_sherr = '0; m_err = '0; m_shadow = '0; m_bcd = '0;
         m_pend = 0; m_pub = 0;
      end else begin
         if (SYNC_DLY == 2) begin
            m_s    = m_dly2;
            m_dly2 = m_dly1;
            m_dly1 = {dig_sel, seg_in};
         end else begin
            m_s = {dig_sel, seg_in};
         end
         if (m_s == m_prev) begin
            if (m_run <= SC) m_run++;
         end else begin
            m_run = 1;
         end
         m_prev = m_s;
         m_cap  = (m_run == SC) && ($countones(m_s[10:7]) == 1);

         m_old_pend = m_pend;
         m_old_pub  = m_pub;
         m_pend = 0;
         m_pub  = 0;
         if (m_old_pub) m_mask = '0;
         if (m_old_pend) begin
            m_bcd = m_shadow;
            m_err = m_sherr;
            m_pub = 1;
         end
         if (m_cap) begin
            for (int i = 0; i < NDIG; i++) begin
               if (m_s[7+i]) begin
                  m_dec = ref_decode(m_s[6:0]);
                  m_shadow[4*i +: 4] = m_dec[3:0];
                  m_sherr[i] = m_dec[4];
                  m_mask[i]  = 1'b1;
               end
            end
         end
         if (m_mask == 4'hF && !m_pub) m_pend = 1;
      end
   end

   always @(posedge clk) begin
      #1;
      check("model frame_valid", {31'b0, frame_valid}, {31'b0, m_pub});
      check("model bcd_out", {16'b0, bcd_out}, {16'b0, m_bcd});
      check("model digit_err", {28'b0, digit_err}, {28'b0, m_err});
      if (frame_valid) pulses++;
   end

   task automatic drive(input logic [3:0] sel, input logic [6:0] pat, input int cyc);
      @(negedge clk);
      dig_sel = sel;
      seg_in  = pat;
      repeat (cyc - 1) @(negedge clk);
   endtask

   // Scans digits 0..3 (digit i = pats[7i+:7]); reports posedges from digit 3's first sample to frame_valid.
   task automatic scan_frame(input logic [27:0] pats, output int lat);
      lat = -1;
      for (int i = 0; i < 3; i++) drive(4'(1 << i), pats[7*i +: 7], 8);
      @(negedge clk);
      dig_sel = 4'b1000;
      seg_in  = pats[27:21];
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (frame_valid && lat < 0) lat = k;
      end
   endtask

   typedef struct {
      logic [27:0] pats;
      logic [15:0] bcd;
      logic [3:0]  err;
   } vec_t;

   vec_t vecs [5];
   int   lat, p0, r;
   logic [3:0] sel;
   logic [6:0] pat;
   int   next_dig = 0;

   initial begin
      vecs[0] = '{pats: {7'h33, 7'h79, 7'h6D, 7'h30}, bcd: 16'h4321, err: 4'b0000};
      vecs[1] = '{pats: {7'h7E, 7'h00, 7'h73, 7'h1F}, bcd: 16'h0F96, err: 4'b0100};
      vecs[2] = '{pats: {7'h5F, 7'h7B, 7'h7F, 7'h7E}, bcd: 16'h6980, err: 4'b0000};
      vecs[3] = '{pats: {7'h30, 7'h77, 7'h70, 7'h5B}, bcd: 16'h1F75, err: 4'b0100};
      vecs[4] = '{pats: {7'h00, 7'h7F, 7'h33, 7'h6D}, bcd: 16'hF842, err: 4'b1000};

      rst_n = 1'b0; dig_sel = '0; seg_in = '0;
      repeat (3) @(negedge clk);
      check("reset bcd_out", {16'b0, bcd_out}, 32'h0);
      check("reset digit_err", {28'b0, digit_err}, 32'h0);
      check("reset frame_valid", {31'b0, frame_valid}, 32'h0);
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         p0 = pulses;
         scan_frame(vecs[v].pats, lat);
         check($sformatf("vec%0d bcd_out", v), {16'b0, bcd_out}, {16'b0, vecs[v].bcd});
         check($sformatf("vec%0d digit_err", v), {28'b0, digit_err}, {28'b0, vecs[v].err});
         check($sformatf("vec%0d pulses", v), 32'(pulses - p0), 32'd1);
         check($sformatf("vec%0d latency", v), 32'(lat), 32'(SC + SYNC_DLY));
      end

      // Glitch: a 3-cycle 8 on digit 1 must not be taken.
      p0 = pulses;
      drive(4'b0001, 7'h30, 8);
      drive(4'b0010, 7'h7F, 3);
      drive(4'b0010, 7'h5B, 8);
      drive(4'b0100, 7'h79, 8);
      drive(4'b1000, 7'h33, 10);
      check("glitch bcd_out", {16'b0, bcd_out}, 32'h4351);
      check("glitch digit_err", {28'b0, digit_err}, 32'h0);
      check("glitch pulses", 32'(pulses - p0), 32'd1);

      // Illegal selects mid-frame.
      p0 = pulses;
      drive(4'b0001, 7'h5F, 8);
      drive(4'b0010, 7'h70, 8);
      drive(4'b0011, 7'h7F, 10);
      drive(4'b1100, 7'h7F, 10);
      drive(4'b0000, 7'h7F, 10);
      check("illegal sel no frame", 32'(pulses - p0), 32'd0);
      drive(4'b0100, 7'h30, 8);
      drive(4'b1000, 7'h6D, 10);
      check("illegal sel bcd_out", {16'b0, bcd_out}, 32'h2176);
      check("illegal sel pulses", 32'(pulses - p0), 32'd1);

      // Reset mid-frame discards digits 0,1; new frame scanned out of order.
      drive(4'b0001, 7'h7F, 8);
      drive(4'b0010, 7'h7F, 8);
      @(negedge clk);
      rst_n = 1'b0; dig_sel = '0; seg_in = '0;
      #1;
      check("mid reset bcd_out", {16'b0, bcd_out}, 32'h0);
      check("mid reset frame_valid", {31'b0, frame_valid}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      p0 = pulses;
      drive(4'b0100, 7'h7F, 8);
      drive(4'b1000, 7'h7F, 8);
      check("after reset partial no frame", 32'(pulses - p0), 32'd0);
      check("after reset bcd_out held 0", {16'b0, bcd_out}, 32'h0);
      drive(4'b0001, 7'h7F, 8);
      drive(4'b0010, 7'h7F, 10);
      check("after reset bcd_out", {16'b0, bcd_out}, 32'h8888);
      check("after reset pulses", 32'(pulses - p0), 32'd1);

      // Back-to-back frames.
      p0 = pulses;
      scan_frame({7'h33, 7'h79, 7'h6D, 7'h30}, lat);
      check("b2b first bcd_out", {16'b0, bcd_out}, 32'h4321);
      check("b2b first latency", 32'(lat), 32'(SC + SYNC_DLY));
      scan_frame({7'h7F, 7'h70, 7'h5F, 7'h5B}, lat);
      check("b2b second bcd_out", {16'b0, bcd_out}, 32'h8765);
      check("b2b second latency", 32'(lat), 32'(SC + SYNC_DLY));
      check("b2b pulses", 32'(pulses - p0), 32'd2);

      // Random scans against the model.
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 40) begin
            sel = 4'(1 << next_dig);
            next_dig = (next_dig + 1) % NDIG;
         end else if (r < 80) begin
            sel = 4'(1 << $urandom_range(0, 3));
         end else begin
            sel = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 99) < 75) pat = legal[$urandom_range(0, 11)];
         else pat = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 99) == 0) begin
            @(negedge clk);
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
         end
         drive(sel, pat, int'($urandom_range(1, 9)));
      end
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Receive side of a multiplexed 7-segment display interface. Samples a time-multiplexed segment bus (seg_in plus one-hot digit select) and decodes each stable segment pattern back to a BCD nibble. Assembles NDIG digits into a frame and publishes the frame with a one-cycle valid pulse. Used to loop back and check display-driver outputs, or to read an external multiplexed display.

Parameters:
NDIG, 4, number of multiplexed digits (2..8)
STABLE_CYC, 4, consecutive identical-sample cycles needed before a digit is captured (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
seg_in  in  7  segment pattern {a,b,c,d,e,f,g}, a=bit6, active-high
dig_sel  in  NDIG  one-hot digit select; bit i selects digit i
bcd_out  out  4*NDIG  last published frame; digit i at [4i+3:4i]
frame_valid  out  1  one-cycle pulse when bcd_out/digit_err update
digit_err  out  NDIG  per-digit flag: pattern not a legal BCD glyph in the published frame

Behaviour:
- Reset: asynchronous on rst_n low, released synchronously. bcd_out=0, frame_valid=0, digit_err=0. Internal capture mask=0, shadow nibbles=0, shadow err=0, stability counter=0, FSM=IDLE.
- Sampled word S = {dig_sel, seg_in}, registered every cycle (sample register s_q).
- Stability counter:
  - If S==s_q, cnt increments, saturating at STABLE_CYC.
  - Else cnt=0.
- Capture strobe: fires exactly once per stable window, on the cycle cnt transitions to STABLE_CYC-1, and only when dig_sel is one-hot. dig_sel=0 or multi-hot never captures and does not disturb the mask.
- Latency: with a new S first present in cycle t, the capture takes effect at the clock edge ending cycle t+STABLE_CYC-1.
- Decode (seg_in hex -> nibble):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
  - Alternates 1F->6 and 73->9 are accepted without error.
  - Any other pattern -> nibble F and the shadow err bit is set.
- On capture of digit i: shadow nibble i and shadow err i are written, and mask bit i is set. Recapturing a digit before the frame completes overwrites its shadow values; the mask is unchanged.
- FSM:
  - IDLE: mask==0. The first capture moves to COLLECT.
  - COLLECT: when the mask becomes all-ones, move to PUBLISH.
  - PUBLISH (one cycle):
    - bcd_out<=shadow nibbles, digit_err<=shadow err, frame_valid=1, mask<=0, then IDLE.
    - A capture strobe in the PUBLISH cycle is applied after the mask clear, so the new digit starts the next frame and is not lost.
- frame_valid is high only in PUBLISH. bcd_out and digit_err hold between publishes.
- Frame completion does not depend on digit order; any scan order works.
- Reset asserted mid-frame discards the partial frame and clears all outputs immediately.

Optional Feature:
SEG_INPUT_SYNC_EN
- Defined: seg_in and dig_sel pass through a 2-flop synchronizer before s_q, for asynchronous external displays. All capture latencies grow by 2 cycles. The synchronizer flops reset to 0.
- Undefined: inputs are assumed synchronous to clk and feed s_q directly.

Test Plan:
- All cases use NDIG=4, STABLE_CYC=4, macro undefined unless stated.
- Normal frame: scan digits 0..3 with patterns 30,6D,79,33, each held 8 cycles -> one frame_valid pulse, bcd_out=16'h4321, digit_err=4'b0000, pulse 1 cycle after digit 3's capture edge.
- Glitch reject: digit 1 pattern 7F held 3 cycles, then 5B held 8 cycles within a full scan -> digit 1 nibble 5; no capture of 8.
- Invalid and alternate glyphs: digits 0..3 = 1F,73,00,7E -> bcd_out=16'h0F96, digit_err=4'b0100.
- Illegal select: dig_sel=4'b0011 or 4'b0000 held 10 cycles mid-frame -> no capture, mask unchanged; the frame completes normally afterwards.
- Reset mid-frame: capture digits 0,1, pulse rst_n low for 2 cycles, then scan a full frame of 8s -> no frame_valid before the new frame; bcd_out=0 during reset; then 16'h8888.
- Back-to-back frames with SEG_INPUT_SYNC_EN defined: two full scans (1234, then 5678) -> two frame_valid pulses, bcd_out 16'h4321 then 16'h8765, each capture 2 cycles later than without the macro.
